// File: rtl/l1_cache_if.sv
// CPU-side word handshake and physical-memory line handshake for l1_cache.
interface l1_cache_if;
    logic         mem_read;
    logic         mem_write;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_address;
    logic [15:0]  mem_wdata;
    logic         mem_resp;
    logic [15:0]  mem_rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_resp, mem_rdata,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_resp, mem_rdata,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/l1_cache.sv
// Direct-mapped write-back/write-allocate cache between the LC-3b CPU and line memory.
// Optional hit/miss counters are enabled by defining L1_CACHE_PERF_CNT_EN.
module l1_cache #(
    parameter int unsigned SET_BITS = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    l1_cache_if.slave   bus
`ifdef L1_CACHE_PERF_CNT_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);
    localparam int unsigned SETS  = 1 << SET_BITS;
    localparam int unsigned TAG_W = 12 - SET_BITS;

    typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, FILL} state_e;

    state_e                state_q, state_d;
    logic [15:1]           addr_q, addr_d;
    logic [SETS-1:0]       valid_q, valid_d;
    logic [SETS-1:0]       dirty_q, dirty_d;
    logic [TAG_W-1:0]      tag_q  [SETS];
    logic [7:0][15:0]      data_q [SETS];

    logic                  mem_resp_q, mem_resp_d;
    logic [15:0]           mem_rdata_q, mem_rdata_d;
    logic                  pmem_read_q, pmem_read_d;
    logic                  pmem_write_q, pmem_write_d;
    logic [15:0]           pmem_address_q, pmem_address_d;
    logic [127:0]          pmem_wdata_q, pmem_wdata_d;

    logic                  req;
    logic                  line_we, word_we;
    logic [SET_BITS-1:0]   in_idx, idx;
    logic [TAG_W-1:0]      in_tag, tag;
    logic [2:0]            in_word, word;
    logic [7:0][15:0]      fill_line;

    assign req       = bus.mem_read | bus.mem_write;
    assign in_idx    = bus.mem_address[SET_BITS+3:4];
    assign in_tag    = bus.mem_address[15:SET_BITS+4];
    assign in_word   = bus.mem_address[3:1];
    assign idx       = addr_q[SET_BITS+3:4];
    assign tag       = addr_q[15:SET_BITS+4];
    assign word      = addr_q[3:1];
    assign fill_line = bus.pmem_rdata;

    assign bus.mem_resp     = mem_resp_q;
    assign bus.mem_rdata    = mem_rdata_q;
    assign bus.pmem_read    = pmem_read_q;
    assign bus.pmem_write   = pmem_write_q;
    assign bus.pmem_address = pmem_address_q;
    assign bus.pmem_wdata   = pmem_wdata_q;

    // Next state; the CHECK response is looked ahead one cycle so outputs stay registered.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        line_we     = 1'b0;
        word_we     = 1'b0;
        mem_resp_d  = 1'b0;
        mem_rdata_d = '0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d     = CHECK;
                    addr_d      = bus.mem_address[15:1];
                    mem_resp_d  = valid_q[in_idx] && (tag_q[in_idx] == in_tag);
                    mem_rdata_d = data_q[in_idx][in_word];
                end
            end
            CHECK: begin
                if (mem_resp_q) begin
                    state_d = IDLE;
                    if (bus.mem_write) begin
                        word_we      = 1'b1;
                        dirty_d[idx] = 1'b1;
                    end
                end else if (!req) begin
                    state_d = IDLE;
                end else if (valid_q[idx] && dirty_q[idx]) begin
                    state_d = WRITEBACK;
                end else begin
                    state_d = FILL;
                end
            end
            WRITEBACK: begin
                if (bus.pmem_resp) begin
                    dirty_d[idx] = 1'b0;
                    state_d      = FILL;
                end
            end
            FILL: begin
                if (bus.pmem_resp) begin
                    line_we      = 1'b1;
                    valid_d[idx] = 1'b1;
                    dirty_d[idx] = 1'b0;
                    state_d      = CHECK;
                    mem_resp_d   = req;
                    mem_rdata_d  = fill_line[word];
                end
            end
            default: state_d = IDLE;
        endcase

        pmem_read_d    = (state_d == FILL);
        pmem_write_d   = (state_d == WRITEBACK);
        pmem_address_d = '0;
        pmem_wdata_d   = '0;
        if (state_d == WRITEBACK) begin
            pmem_address_d = {tag_q[idx], idx, 4'b0000};
            pmem_wdata_d   = data_q[idx];
        end else if (state_d == FILL) begin
            pmem_address_d = {tag, idx, 4'b0000};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            valid_q        <= '0;
            dirty_q        <= '0;
            mem_resp_q     <= 1'b0;
            mem_rdata_q    <= '0;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            valid_q        <= valid_d;
            dirty_q        <= dirty_d;
            mem_resp_q     <= mem_resp_d;
            mem_rdata_q    <= mem_rdata_d;
            pmem_read_q    <= pmem_read_d;
            pmem_write_q   <= pmem_write_d;
            pmem_address_q <= pmem_address_d;
            pmem_wdata_q   <= pmem_wdata_d;
        end
    end

    // Tag and data arrays carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (line_we) begin
            data_q[idx] <= bus.pmem_rdata;
            tag_q[idx]  <= tag;
        end
        if (word_we) begin
            if (bus.mem_byte_enable[0]) data_q[idx][word][7:0]  <= bus.mem_wdata[7:0];
            if (bus.mem_byte_enable[1]) data_q[idx][word][15:8] <= bus.mem_wdata[15:8];
        end
    end

`ifdef L1_CACHE_PERF_CNT_EN
    logic        prev_idle_q;
    logic [15:0] hit_q, miss_q;

    // Only first-look hits count; the re-check after a fill is excluded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_idle_q <= 1'b0;
            hit_q       <= '0;
            miss_q      <= '0;
        end else begin
            prev_idle_q <= (state_q == IDLE);
            if (state_q == CHECK && mem_resp_q && prev_idle_q && hit_q != 16'hFFFF)
                hit_q <= hit_q + 16'd1;
            if (state_q == CHECK && (state_d == FILL || state_d == WRITEBACK) && miss_q != 16'hFFFF)
                miss_q <= miss_q + 16'd1;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`endif
endmodule

// File: tb/tb_l1_cache.sv
// Scoreboard bench for l1_cache: directed CPU requests, a line-memory responder and a response monitor.
module tb_l1_cache;
    localparam int MEM_LAT = 2;

    typedef struct packed {
        logic        chk;
        logic [15:0] data;
    } cpu_exp_t;

    typedef struct packed {
        logic         wr;
        logic [15:0]  addr;
        logic [127:0] wdata;
    } pm_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    l1_cache_if bus ();
`ifdef L1_CACHE_PERF_CNT_EN
    logic [15:0] hit_count, miss_count;
`endif

    l1_cache #(.SET_BITS(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef L1_CACHE_PERF_CNT_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    cpu_exp_t     cpu_q[$];
    pm_exp_t      pm_q[$];
    logic [127:0] pmem [logic [15:0]];
    int           n_cmp = 0;
    int           n_bad = 0;
    logic         cpu_active = 1'b0;
    cpu_exp_t     mon_e;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [127:0] default_line(input logic [15:0] a);
        logic [7:0][15:0] l;
        for (int w = 0; w < 8; w++) l[w] = {a[11:4], 4'hA, 4'(w)};
        return l;
    endfunction

    function automatic pm_exp_t pm(input logic wr, input logic [15:0] a, input logic [127:0] d);
        pm_exp_t p;
        p.wr = wr; p.addr = a; p.wdata = d;
        return p;
    endfunction

    // CPU response monitor.
    always @(negedge clk) begin
        if (rst_n && bus.mem_resp) begin
            if (cpu_q.size() == 0) begin
                flag("unexpected_mem_resp");
            end else begin
                mon_e = cpu_q.pop_front();
                if (mon_e.chk) check("mem_rdata", 128'(bus.mem_rdata), 128'(mon_e.data));
            end
        end
        if (bus.pmem_read && bus.pmem_write) flag("pmem_read_and_write");
    end

    // Line memory: checks each new request on first sight, answers after MEM_LAT cycles.
    initial begin
        int          wait_cnt = 0;
        logic        fill_done = 1'b0;
        logic [15:0] pa = '0;
        pm_exp_t     pe;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (fill_done) begin
                fill_done = 1'b0;
                if (cpu_active) check("resp_after_fill", 128'(bus.mem_resp), 128'(1));
            end
            bus.pmem_resp = 1'b0;
            if (!rst_n || !(bus.pmem_read || bus.pmem_write)) begin
                wait_cnt = 0;
            end else begin
                if (wait_cnt == 0) begin
                    pa = bus.pmem_address;
                    if (pm_q.size() == 0) begin
                        flag("unexpected_pmem_request");
                    end else begin
                        pe = pm_q.pop_front();
                        check("pmem_write", 128'(bus.pmem_write), 128'(pe.wr));
                        check("pmem_address", 128'(pa), 128'(pe.addr));
                        if (pe.wr) check("pmem_wdata", bus.pmem_wdata, pe.wdata);
                    end
                end
                if (wait_cnt == MEM_LAT) begin
                    if (bus.pmem_write) begin
                        pmem[pa] = bus.pmem_wdata;
                    end else begin
                        bus.pmem_rdata = pmem.exists(pa) ? pmem[pa] : default_line(pa);
                        fill_done = 1'b1;
                    end
                    bus.pmem_resp = 1'b1;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // One CPU transaction; exp_lat counts request cycles up to and including mem_resp (0 = unchecked).
    task automatic cpu_req(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                           input logic [1:0] be, input logic chk, input logic [15:0] exp, input int exp_lat);
        int n = 0;
        cpu_exp_t ce;
        ce.chk = chk; ce.data = exp;
        cpu_q.push_back(ce);
        bus.mem_read = rd; bus.mem_write = wr; bus.mem_address = a;
        bus.mem_wdata = d; bus.mem_byte_enable = be;
        cpu_active = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.mem_resp && n < 100);
        if (!bus.mem_resp) flag("cpu_timeout");
        else if (exp_lat != 0) check("hit_latency", 128'(n + 1), 128'(exp_lat));
        @(posedge clk);
        #1;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        cpu_active = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_perf(input logic [15:0] hits, input logic [15:0] misses);
`ifdef L1_CACHE_PERF_CNT_EN
        check("hit_count", 128'(hit_count), 128'(hits));
        check("miss_count", 128'(miss_count), 128'(misses));
`else
        if (hits == misses) begin end
`endif
    endtask

    initial begin
        logic [127:0] line_a, line_a2, line_b, line_b2;
        int n;
        line_a  = {16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'hBEEF, 16'h1111};
        line_a2 = {16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'hBE34, 16'h1111};
        line_b  = {16'h7070, 16'h6060, 16'h5050, 16'h4040, 16'h3030, 16'h2020, 16'hCAFE, 16'h1010};
        line_b2 = {16'hA570, 16'h6060, 16'h5050, 16'h4040, 16'h3030, 16'h9999, 16'hCAFE, 16'h1010};
        pmem[16'h1000] = line_a;
        pmem[16'h1080] = line_b;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_byte_enable = 2'b00;
        bus.mem_address = '0; bus.mem_wdata = '0;

        repeat (3) @(negedge clk);
        check("rst_mem_resp", 128'(bus.mem_resp), 128'(0));
        check("rst_pmem_read", 128'(bus.pmem_read), 128'(0));
        check("rst_pmem_write", 128'(bus.pmem_write), 128'(0));
        check("rst_pmem_address", 128'(bus.pmem_address), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check_perf(16'd0, 16'd0);

        // Cold miss, then hits, then a partial write.
        pm_q.push_back(pm(1'b0, 16'h1000, '0));
        cpu_req(1'b1, 1'b0, 16'h1002, 16'h0000, 2'b00, 1'b1, 16'hBEEF, 0);
        cpu_req(1'b1, 1'b0, 16'h1002, 16'h0000, 2'b00, 1'b1, 16'hBEEF, 2);
        check_perf(16'd1, 16'd1);
        cpu_req(1'b0, 1'b1, 16'h1002, 16'h1234, 2'b01, 1'b0, 16'h0000, 2);
        cpu_req(1'b1, 1'b0, 16'h1002, 16'h0000, 2'b00, 1'b1, 16'hBE34, 2);

        // Conflict miss evicts the dirty line first.
        pm_q.push_back(pm(1'b1, 16'h1000, line_a2));
        pm_q.push_back(pm(1'b0, 16'h1080, '0));
        cpu_req(1'b1, 1'b0, 16'h1082, 16'h0000, 2'b00, 1'b1, 16'hCAFE, 0);

        // High-byte write, empty-mask write, read+write treated as write.
        cpu_req(1'b0, 1'b1, 16'h108E, 16'hA5C3, 2'b10, 1'b0, 16'h0000, 2);
        cpu_req(1'b0, 1'b1, 16'h108C, 16'hFFFF, 2'b00, 1'b0, 16'h0000, 2);
        cpu_req(1'b1, 1'b0, 16'h108E, 16'h0000, 2'b00, 1'b1, 16'hA570, 2);
        cpu_req(1'b1, 1'b0, 16'h108C, 16'h0000, 2'b00, 1'b1, 16'h6060, 2);
        cpu_req(1'b1, 1'b1, 16'h1084, 16'h9999, 2'b11, 1'b0, 16'h0000, 2);
        cpu_req(1'b1, 1'b0, 16'h1084, 16'h0000, 2'b00, 1'b1, 16'h9999, 2);

        // Evict again; refill must return the earlier written-back byte.
        pm_q.push_back(pm(1'b1, 16'h1080, line_b2));
        pm_q.push_back(pm(1'b0, 16'h1000, '0));
        cpu_req(1'b1, 1'b0, 16'h1002, 16'h0000, 2'b00, 1'b1, 16'hBE34, 0);
        check("pmem_all_seen", 128'(pm_q.size()), 128'(0));
        check_perf(16'd9, 16'd3);

        // Reset in the middle of a fill.
        pm_q.push_back(pm(1'b0, 16'h2000, '0));
        bus.mem_read = 1'b1; bus.mem_address = 16'h2002;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.pmem_read && n < 20);
        if (!bus.pmem_read) flag("fill_start_timeout");
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_fill_pmem_read", 128'(bus.pmem_read), 128'(0));
        check("rst_mid_fill_mem_resp", 128'(bus.mem_resp), 128'(0));
        bus.mem_read = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_perf(16'd0, 16'd0);

        pm_q.push_back(pm(1'b0, 16'h2000, '0));
        cpu_req(1'b1, 1'b0, 16'h2002, 16'h0000, 2'b00, 1'b1, 16'h00A1, 0);
        check("refill_after_reset", 128'(pm_q.size()), 128'(0));
        check_perf(16'd0, 16'd1);

        repeat (5) @(negedge clk);
        check("cpu_all_responded", 128'(cpu_q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
